// File: rtl/spike_packetizer.sv
// Turns accepted neuron spike bitmaps into one 42-bit spike packet per fired neuron, lowest index first.
// Optional SPIKE_PACKETIZER_TIMESTAMP_EN adds a timestep counter whose latched value fills the payload.
module spike_packetizer #(
  parameter int         NUM_NEURONS = 16,
  parameter logic [6:0] BASE_ADDR   = 7'd0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_spike_valid,
  input  logic [NUM_NEURONS-1:0] i_spike_vec,
  output logic                   o_spike_ready,
  input  logic                   i_tick,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [41:0]            o_data,
  output logic                   o_busy
);

  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                 state_r;
  logic [NUM_NEURONS-1:0] pending_r;
  logic [NUM_NEURONS-1:0] pending_clr_s;
  logic [IW-1:0]          low_idx_s;
  logic [6:0]             addr_s;
  logic [31:0]            payload_s;
  logic                   idle_r;
  logic                   accept_s;

  function automatic logic [IW-1:0] lowest_set(input logic [NUM_NEURONS-1:0] vec);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Next packet selection: lowest pending neuron, its wrapped address and the pending set after it is sent
  always_comb begin
    low_idx_s     = lowest_set(pending_r);
    addr_s        = BASE_ADDR + 7'(low_idx_s);
    pending_clr_s = pending_r & ~(NUM_NEURONS'(1) << low_idx_s);
  end

  // Ready is forced low for as long as reset is held, and rises as soon as it is released
  assign o_spike_ready = idle_r & i_rst_n;
  assign accept_s      = (state_r == IDLE) && i_spike_valid && o_spike_ready;

`ifdef SPIKE_PACKETIZER_TIMESTAMP_EN
  logic [31:0] ts_cnt_r;
  logic [31:0] ts_latch_r;

  // Free-running timestep counter; the latch takes the pre-increment value on a coincident tick
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ts_cnt_r   <= 32'd0;
      ts_latch_r <= 32'd0;
    end else begin
      if (i_tick) ts_cnt_r <= ts_cnt_r + 32'd1;
      if (accept_s && (|i_spike_vec)) ts_latch_r <= ts_cnt_r;
    end
  end

  assign payload_s = ts_latch_r;
`else
  logic unused_tick_s;
  assign unused_tick_s = i_tick;
  assign payload_s     = 32'd0;
`endif

  // Control FSM with registered packet outputs; reset drops any in-flight packet and all pending bits
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      pending_r <= '0;
      o_valid   <= 1'b0;
      o_data    <= 42'd0;
      o_busy    <= 1'b0;
      idle_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          o_valid <= 1'b0;
          if (accept_s && (|i_spike_vec)) begin
            pending_r <= i_spike_vec;
            state_r   <= SCAN;
            o_busy    <= 1'b1;
            idle_r    <= 1'b0;
          end
        end
        SCAN: begin
          o_data  <= {3'b001, addr_s, payload_s};
          o_valid <= 1'b1;
          state_r <= SEND;
        end
        SEND: begin
          if (i_ready) begin
            o_valid   <= 1'b0;
            pending_r <= pending_clr_s;
            if (|pending_clr_s) begin
              state_r <= SCAN;
            end else begin
              state_r <= IDLE;
              o_busy  <= 1'b0;
              idle_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= '0;
          o_valid   <= 1'b0;
          o_busy    <= 1'b0;
          idle_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer: two instances (BASE_ADDR 10 and 126) driven by shared stimulus.
module tb_spike_packetizer;

  logic        clk;
  logic        rst_n;
  logic        spike_valid;
  logic [15:0] spike_vec;
  logic        tick;
  logic        ready;

  logic        spike_ready0, valid0, busy0;
  logic [41:0] data0;
  logic        spike_ready1, valid1, busy1;
  logic [41:0] data1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SPIKE_PACKETIZER_TIMESTAMP_EN
  localparam logic [31:0] EXP_TS = 32'd3;
`else
  localparam logic [31:0] EXP_TS = 32'd0;
`endif

  spike_packetizer #(.NUM_NEURONS(16), .BASE_ADDR(7'd10)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike_valid(spike_valid), .i_spike_vec(spike_vec),
    .o_spike_ready(spike_ready0), .i_tick(tick), .o_valid(valid0), .i_ready(ready),
    .o_data(data0), .o_busy(busy0)
  );

  spike_packetizer #(.NUM_NEURONS(16), .BASE_ADDR(7'd126)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike_valid(spike_valid), .i_spike_vec(spike_vec),
    .o_spike_ready(spike_ready1), .i_tick(tick), .o_valid(valid1), .i_ready(ready),
    .o_data(data1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spike_valid = 1'b0; spike_vec = 16'h0000; tick = 1'b0; ready = 1'b0;
    step(); step();
    n_cmp++; if (spike_ready0 !== 1'b0) begin n_err++; $display("FAIL rst_ready_low: got %b want 0", spike_ready0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid0); end
    n_cmp++; if (data0 !== 42'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", data0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy0); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (spike_ready0 !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", spike_ready0); end
    step();
    n_cmp++; if (spike_ready0 !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", spike_ready0); end
  endtask

  task automatic test_zero_vector();
    spike_valid = 1'b1; spike_vec = 16'h0000; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (spike_ready0 !== 1'b1) begin n_err++; $display("FAIL zero_ready[%0d]: got %b want 1", i, spike_ready0); end
      n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL zero_valid[%0d]: got %b want 0", i, valid0); end
    end
    spike_valid = 1'b0;
  endtask

  task automatic test_two_packets();
    ready = 1'b1; spike_valid = 1'b1; spike_vec = 16'h0081;
    step();
    spike_valid = 1'b0;
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL two_valid_acc: got %b want 0", valid0); end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL two_busy: got %b want 1", busy0); end
    n_cmp++; if (spike_ready0 !== 1'b0) begin n_err++; $display("FAIL two_ready_low: got %b want 0", spike_ready0); end
    step();
    n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL two_valid_p0: got %b want 1", valid0); end
    n_cmp++; if (data0[41:32] !== {3'b001, 7'd10}) begin n_err++; $display("FAIL two_hdr_p0: got %h want %h", data0[41:32], {3'b001, 7'd10}); end
    step();
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL two_gap: got %b want 0", valid0); end
    step();
    n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL two_valid_p1: got %b want 1", valid0); end
    n_cmp++; if (data0[41:32] !== {3'b001, 7'd17}) begin n_err++; $display("FAIL two_hdr_p1: got %h want %h", data0[41:32], {3'b001, 7'd17}); end
    step();
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL two_end_valid: got %b want 0", valid0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL two_end_busy: got %b want 0", busy0); end
    n_cmp++; if (spike_ready0 !== 1'b1) begin n_err++; $display("FAIL two_end_ready: got %b want 1", spike_ready0); end
  endtask

  task automatic test_backpressure();
    logic [41:0] exp_data;
    exp_data = {3'b001, 7'd12, 32'd0};
    ready = 1'b0; spike_valid = 1'b1; spike_vec = 16'h0004;
    step();
    spike_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, valid0); end
      n_cmp++; if (data0 !== exp_data) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, data0, exp_data); end
      if (i < 4) step();
    end
    ready = 1'b1;
    step();
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL bp_done_valid: got %b want 0", valid0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL bp_done_busy: got %b want 0", busy0); end
    n_cmp++; if (spike_ready0 !== 1'b1) begin n_err++; $display("FAIL bp_done_ready: got %b want 1", spike_ready0); end
  endtask

  task automatic test_wrap();
    ready = 1'b1; spike_valid = 1'b1; spike_vec = 16'h0004;
    step();
    spike_valid = 1'b0;
    step();
    n_cmp++; if (valid1 !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", valid1); end
    n_cmp++; if (data1[41:32] !== {3'b001, 7'd0}) begin n_err++; $display("FAIL wrap_hdr: got %h want %h", data1[41:32], {3'b001, 7'd0}); end
    step();
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL wrap_busy: got %b want 0", busy1); end
  endtask

  task automatic test_timestamp();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    tick = 1'b1; spike_valid = 1'b1; spike_vec = 16'h0002;
    step();
    tick = 1'b0; spike_valid = 1'b0;
    step();
    n_cmp++; if (data0[31:0] !== EXP_TS) begin n_err++; $display("FAIL ts_payload: got %h want %h", data0[31:0], EXP_TS); end
    n_cmp++; if (data0[38:32] !== 7'd11) begin n_err++; $display("FAIL ts_addr: got %h want %h", data0[38:32], 7'd11); end
    ready = 1'b1;
    step();
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL ts_busy: got %b want 0", busy0); end
  endtask

  task automatic test_reset_mid_send();
    ready = 1'b1; spike_valid = 1'b1; spike_vec = 16'hFFFF;
    step();
    spike_valid = 1'b0;
    step(); step(); step(); step(); step();
    n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL mid_third_valid: got %b want 1", valid0); end
    n_cmp++; if (data0[38:32] !== 7'd12) begin n_err++; $display("FAIL mid_third_addr: got %h want %h", data0[38:32], 7'd12); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", valid0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy0); end
    n_cmp++; if (spike_ready0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", spike_ready0); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (spike_ready0 !== 1'b1) begin n_err++; $display("FAIL mid_release_ready: got %b want 1", spike_ready0); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL mid_no_packet[%0d]: got %b want 0", i, valid0); end
    end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL mid_idle_busy: got %b want 0", busy0); end
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_two_packets();
    test_backpressure();
    test_wrap();
    test_timestamp();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
